seq_divider_16x8: RTL and testbench

//   Iterative restoring unsigned divider, 2W-bit dividend / W-bit divisor -> 2W-bit quotient, W-bit remainder.

---
 rtl/seq_divider_16x8_pkg.sv | 18 +
 rtl/seq_divider_16x8_if.sv | 43 ++++
 rtl/seq_divider_16x8_lzc.sv | 21 ++
 rtl/seq_divider_16x8.sv | 137 +++++++++++++
 tb/tb_seq_divider_16x8.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/seq_divider_16x8_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// State encoding plus the width of the iteration counter.
package seq_div_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value 2W itself, hence 2W+1 states
  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_16x8_if.sv
// Operand/result handshake bundle for the divider: valid/ready on both sides.
// slave = divider side, master = producer/consumer side.
interface seq_div_if
  import seq_div_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;

  modport slave (
    input  in_valid,
    output in_ready,
    input  dividend,
    input  divisor,
    output out_valid,
    input  out_ready,
    output quotient,
    output remainder,
    output div_by_zero
  );

  modport master (
    output in_valid,
    input  in_ready,
    output dividend,
    output divisor,
    input  out_valid,
    output out_ready,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

endinterface

// File: rtl/seq_divider_16x8_lzc.sv
// div_lzc: N-bit leading-zero counter, purely combinational (zero latency, no handshake).
// An all-zero input reports N.
module div_lzc #(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  value,
  output logic [CW-1:0] count
);

  // Ascending scan: the highest set bit is the last one to overwrite count
  always_comb begin
    count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (value[i]) begin
        count = CW'(N - 1 - i);
      end
    end
  end

endmodule

// File: rtl/seq_divider_16x8.sv
// Iterative restoring divider, 2W/W -> 2W quotient + W remainder, one quotient bit per clock.
// Latency 2W edges after accept (divide-by-zero: DONE on the accept edge); result held until out_ready. Optional SEQ_DIV_SKIP_ZEROS_EN skips leading dividend zeros.
module seq_divider_16x8
  import seq_div_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_div_if.slave bus
);

  localparam int CW = cnt_width(W);

  state_t         state;
  state_t         state_next;
  logic [2*W-1:0] q_reg;
  logic [W-1:0]   rem_reg;
  logic [W-1:0]   dvs_reg;
  logic [CW-1:0]  count;
  logic           dbz;

  logic           accept;
  logic           dvs_zero;
  logic [2*W-1:0] load_q;
  logic [CW-1:0]  load_cnt;
  logic           zero_dvd;

  logic [W:0]     shifted;
  logic           borrow;
  logic [W-1:0]   diff_lo;

  assign accept   = bus.in_valid && (state == IDLE);
  assign dvs_zero = (bus.divisor == '0);

`ifdef SEQ_DIV_SKIP_ZEROS_EN
  logic [CW-1:0] lz;

  div_lzc #(
    .N  (2 * W),
    .CW (CW)
  ) u_lzc (
    .value (bus.dividend),
    .count (lz)
  );

  // Pre-align the dividend so the first CALC step sees its leading one
  assign load_q   = bus.dividend << lz;
  assign load_cnt = CW'(2 * W) - lz;
  assign zero_dvd = (lz == CW'(2 * W));
`else
  assign load_q   = bus.dividend;
  assign load_cnt = CW'(2 * W);
  assign zero_dvd = 1'b0;
`endif

  // When no borrow the true difference is below the divisor, so only the low W bits matter
  assign shifted = {rem_reg, q_reg[2*W-1]};
  assign borrow  = (shifted < {1'b0, dvs_reg});
  assign diff_lo = shifted[W-1:0] - dvs_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          state_next = (dvs_zero || zero_dvd) ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
      count   <= '0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvs_reg <= bus.divisor;
            if (dvs_zero) begin
              q_reg   <= '1;
              rem_reg <= bus.dividend[W-1:0];
              count   <= '0;
              dbz     <= 1'b1;
            end else begin
              // A zero dividend in skip mode loads q=0, rem=0 which is already the answer
              q_reg   <= load_q;
              rem_reg <= '0;
              count   <= load_cnt;
              dbz     <= 1'b0;
            end
          end
        end
        CALC: begin
          q_reg   <= {q_reg[2*W-2:0], ~borrow};
          rem_reg <= borrow ? shifted[W-1:0] : diff_lo;
          count   <= count - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.quotient    = q_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Directed self-checking bench for seq_divider_16x8; expected latencies follow SEQ_DIV_SKIP_ZEROS_EN.
// Latency is counted in rising edges after the accept edge (0 = DONE entered on the accept edge).
module tb_seq_divider_16x8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_div_if #(.W(8)) bus ();

  seq_divider_16x8 #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_DIV_SKIP_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle
  task automatic do_div(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                        input int elat, input int hold);
    int lat;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = b ^ 8'h5A;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (elat >= 0) check({name, ".lat"}, lat, elat);
    check({name, ".q"}, {16'h0, bus.quotient}, {16'h0, eq});
    check({name, ".r"}, {24'h0, bus.remainder}, {24'h0, er});
    check({name, ".dbz"}, {31'h0, bus.div_by_zero}, {31'h0, edbz});
    check({name, ".in_ready_done"}, {31'h0, bus.in_ready}, 32'h0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.divisor  = 8'd1;
      bus.dividend = 16'h1234;
      @(posedge clk);
      #1;
      check({name, ".hold_vld"}, {31'h0, bus.out_valid}, 32'h1);
      check({name, ".hold_q"}, {16'h0, bus.quotient}, {16'h0, eq});
      check({name, ".hold_r"}, {24'h0, bus.remainder}, {24'h0, er});
      check({name, ".hold_rdy"}, {31'h0, bus.in_ready}, 32'h0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, ".vld_drop"}, {31'h0, bus.out_valid}, 32'h0);
    check({name, ".rdy_rise"}, {31'h0, bus.in_ready}, 32'h1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [15:0] gq;
    logic [7:0]  gr;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    #2;
    check("rst.in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("rst.out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst.q", {16'h0, bus.quotient}, 32'h0);
    check("rst.r", {24'h0, bus.remainder}, 32'h0);
    check("rst.dbz", {31'h0, bus.div_by_zero}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_div("d200_7",    16'd200,   8'd7,   16'd28,    8'd4,    1'b0, SKIP ? 8 : 16, 0);
    do_div("d65535_1",  16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 16, 0);
    do_div("d255_255",  16'd255,   8'd255, 16'd1,     8'd0,    1'b0, SKIP ? 8 : 16, 0);
    do_div("d100_0",    16'd100,   8'd0,   16'hFFFF,  8'h64,   1'b1, 0, 0);
    do_div("bp12345",   16'd12345, 8'd123, 16'd100,   8'd45,   1'b0, SKIP ? 14 : 16, 5);

    // Reset in the middle of CALC (40000 has no leading zeros, so both builds are mid-flight)
    bus.dividend = 16'd40000;
    bus.divisor  = 8'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("midrst.in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("midrst.q", {16'h0, bus.quotient}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_div("d1000_10",  16'd1000,  8'd10,  16'd100,   8'd0,    1'b0, SKIP ? 10 : 16, 0);
    do_div("d5_3",      16'd5,     8'd3,   16'd1,     8'd2,    1'b0, SKIP ? 3 : 16, 0);
    do_div("d0_9",      16'd0,     8'd9,   16'd0,     8'd0,    1'b0, SKIP ? 0 : 16, 0);

    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if (rb == 8'd0) begin
        gq = 16'hFFFF;
        gr = ra[7:0];
      end else begin
        gq = ra / {8'h0, rb};
        gr = 8'(ra % {8'h0, rb});
      end
      do_div("rand", ra, rb, gq, gr, (rb == 8'd0), -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
